alu_rs_scheduler: RTL
=====================

Name: alu_rs_scheduler

Overview:
- Reservation station in front of the ALU. Holds dispatched ALU/branch/address ops until both operands are available.
- Snoops the two result buses (ALU CDB, LSB CDB) to wake up waiting operands.
- Each cycle, issues at most one ready entry to the ALU (lowest index wins).
- Sits between the issue/dispatch stage and the ALU; the ROB drives its flush.

Parameters:
- RS_SIZE, 8, number of entries (power of 2).
- RS_IDX_W, 3, log2(RS_SIZE).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- rdy  in  1  global ready; when low, the block freezes.
- flush  in  1  ROB misprediction rollback; clears all entries.
- dp_sgn  in  1  dispatch valid.
- dp_opcode  in  6  ALU opcode (same encoding the ALU decodes).
- dp_ROB_name  in  4  destination ROB tag.
- dp_Vj  in  32  operand 1 value (meaningful when dp_Qj_busy=0).
- dp_Qj_busy  in  1  operand 1 still pending.
- dp_Qj  in  4  ROB tag producing operand 1.
- dp_Vk  in  32  operand 2 value or immediate.
- dp_Qk_busy  in  1  operand 2 still pending.
- dp_Qk  in  4  ROB tag producing operand 2.
- RS_full  out  1  no free entry.
- CDB_sgn, CDB_ROB_name, CDB_result  in  1/4/32  ALU result broadcast.
- LSB_CDB_sgn, LSB_CDB_ROB_name, LSB_CDB_result  in  1/4/32  load result broadcast.
- ALU_sgn  out  1  issue valid (registered).
- ALU_opcode  out  6  issued opcode (registered).
- ALU_ROB_name  out  4  issued ROB tag (registered).
- ALU_lhs  out  32  issued operand 1 (registered).
- ALU_rhs  out  32  issued operand 2 (registered).

Behaviour:
- Per-entry state: busy, opcode, ROB_name, Vj, Qj, Qj_busy, Vk, Qk, Qk_busy.
- Reset (async, rst=1): all busy=0; ALU_sgn=0; ALU_opcode/ALU_ROB_name/ALU_lhs/ALU_rhs=0. RS_full is then 0.
- rdy=0: no entry, wakeup or dispatch state changes; ALU_sgn<=0 so the ALU sees no repeat issue; other ALU_* outputs hold.
- Priority at each edge with rdy=1: flush > everything else.
  - flush=1: all busy<=0, ALU_sgn<=0, dispatch dropped.
- Dispatch (dp_sgn=1, rdy=1, !flush, !RS_full):
  - Writes the lowest-index free entry at the edge.
  - dp_sgn while RS_full=1 is ignored (no overwrite). The dispatcher must not assert it.
- RS_full is combinational: 1 iff all busy=1. It does not credit an issue happening in the same cycle.
- Wakeup: for every busy entry, and for the entry being written by dispatch:
  - if Qx_busy and a CDB is valid with tag==Qx, then Vx<=result and Qx_busy<=0.
  - Both CDBs are checked. If both match the same tag (illegal), the ALU CDB wins.
- Same-cycle forwarding: a dispatched operand whose tag matches a valid CDB in the dispatch cycle is captured as ready.
- Select: combinational over registered state. Candidate = busy && !Qj_busy && !Qk_busy; pick the lowest index.
  - A woken or newly written entry becomes a candidate from the next cycle.
- Issue: if a candidate exists (rdy=1, !flush):
  - ALU_sgn<=1; ALU_opcode/ALU_ROB_name/ALU_lhs(Vj)/ALU_rhs(Vk)<=entry fields; that entry busy<=0 at the same edge.
  - Otherwise ALU_sgn<=0.
- Issue and dispatch in the same cycle are both allowed. Dispatch targets a free entry, never the issuing one; the freed slot is reusable next cycle.
- Latency: dispatch with ready operands at edge t gives ALU_sgn=1 after edge t+1. Throughput is 1 issue per cycle.
- Tags are compared as 4-bit equality. No ordering or age is tracked; program order is restored by the ROB.

Test Plan:
- Reset then idle -> ALU_sgn=0, RS_full=0, all ALU_* = 0. Assert rst mid-stream with 3 busy entries -> entries are cleared immediately and none issues afterwards.
- Dispatch ADD, Vj=5, Vk=7, both ready, at edge t -> after edge t+1: ALU_sgn=1, ALU_lhs=5, ALU_rhs=7, ALU_ROB_name=dp tag. After edge t+2: ALU_sgn=0.
- Dispatch SUB with Qj_busy, Qj=3. Drive LSB_CDB tag 3 = 0x100 two cycles later -> issues the cycle after wakeup with lhs=0x100. Separately, dispatch with Qk=4 while CDB tag 4 = 9 in the same cycle -> captured, issues with rhs=9.
- Fill 8 entries all waiting on tag 2 -> RS_full=1; a ninth dp_sgn is ignored. CDB tag 2 = 1 -> entries 0..7 issue in index order over 8 consecutive cycles; RS_full drops after the first issue.
- Hold rdy=0 for 3 cycles with a ready entry -> ALU_sgn=0 throughout and no state change. rdy=1 -> the entry issues once.
- flush together with dp_sgn and a ready entry -> next cycle ALU_sgn=0, RS_full=0, no entries remain, and the dispatched op is lost.

Source files
------------

// File: rtl/alu_rs_scheduler.sv
// rtl/alu_rs_scheduler.sv - ALU reservation station with dual-CDB wakeup and lowest-index issue
// Entries wait for both operands, snoop ALU/LSB result buses, and issue one ready entry per cycle.
module alu_rs_scheduler #(
  parameter int RS_SIZE  = 8,
  parameter int RS_IDX_W = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        flush,
  input  logic        dp_sgn,
  input  logic [5:0]  dp_opcode,
  input  logic [3:0]  dp_ROB_name,
  input  logic [31:0] dp_Vj,
  input  logic        dp_Qj_busy,
  input  logic [3:0]  dp_Qj,
  input  logic [31:0] dp_Vk,
  input  logic        dp_Qk_busy,
  input  logic [3:0]  dp_Qk,
  output logic        RS_full,
  input  logic        CDB_sgn,
  input  logic [3:0]  CDB_ROB_name,
  input  logic [31:0] CDB_result,
  input  logic        LSB_CDB_sgn,
  input  logic [3:0]  LSB_CDB_ROB_name,
  input  logic [31:0] LSB_CDB_result,
  output logic        ALU_sgn,
  output logic [5:0]  ALU_opcode,
  output logic [3:0]  ALU_ROB_name,
  output logic [31:0] ALU_lhs,
  output logic [31:0] ALU_rhs
);

  logic [RS_SIZE-1:0] busy_q, busy_d, qjb_q, qjb_d, qkb_q, qkb_d;
  logic [5:0]  op_q  [RS_SIZE];
  logic [5:0]  op_d  [RS_SIZE];
  logic [3:0]  rob_q [RS_SIZE];
  logic [3:0]  rob_d [RS_SIZE];
  logic [3:0]  qj_q  [RS_SIZE];
  logic [3:0]  qj_d  [RS_SIZE];
  logic [3:0]  qk_q  [RS_SIZE];
  logic [3:0]  qk_d  [RS_SIZE];
  logic [31:0] vj_q  [RS_SIZE];
  logic [31:0] vj_d  [RS_SIZE];
  logic [31:0] vk_q  [RS_SIZE];
  logic [31:0] vk_d  [RS_SIZE];

  logic        alu_sgn_q, alu_sgn_d;
  logic [5:0]  alu_op_q, alu_op_d;
  logic [3:0]  alu_rob_q, alu_rob_d;
  logic [31:0] alu_lhs_q, alu_lhs_d, alu_rhs_q, alu_rhs_d;

  logic                sel_found, free_found;
  logic [RS_IDX_W-1:0] sel_idx, free_idx;
  logic [32:0]         wr;

  // Returns {still_pending, value}; the ALU CDB is checked last so it wins a tag tie.
  function automatic logic [32:0] wake(
    input logic qb, input logic [3:0] q, input logic [31:0] v,
    input logic a_sgn, input logic [3:0] a_tag, input logic [31:0] a_res,
    input logic l_sgn, input logic [3:0] l_tag, input logic [31:0] l_res);
    logic [32:0] r;
    r = {qb, v};
    if (qb && l_sgn && (l_tag == q)) r = {1'b0, l_res};
    if (qb && a_sgn && (a_tag == q)) r = {1'b0, a_res};
    return r;
  endfunction

  assign RS_full = &busy_q;

  always_comb begin
    sel_found  = 1'b0;
    sel_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (busy_q[i] && !qjb_q[i] && !qkb_q[i]) begin
        sel_found = 1'b1;
        sel_idx   = i[RS_IDX_W-1:0];
      end
      if (!busy_q[i]) begin
        free_found = 1'b1;
        free_idx   = i[RS_IDX_W-1:0];
      end
    end
  end

  always_comb begin
    busy_d    = busy_q;
    qjb_d     = qjb_q;
    qkb_d     = qkb_q;
    op_d      = op_q;
    rob_d     = rob_q;
    qj_d      = qj_q;
    qk_d      = qk_q;
    vj_d      = vj_q;
    vk_d      = vk_q;
    alu_sgn_d = 1'b0;
    alu_op_d  = alu_op_q;
    alu_rob_d = alu_rob_q;
    alu_lhs_d = alu_lhs_q;
    alu_rhs_d = alu_rhs_q;
    wr        = '0;
    if (rdy && flush) begin
      busy_d = '0;
    end else if (rdy) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy_q[i]) begin
          wr = wake(qjb_q[i], qj_q[i], vj_q[i], CDB_sgn, CDB_ROB_name, CDB_result,
                    LSB_CDB_sgn, LSB_CDB_ROB_name, LSB_CDB_result);
          qjb_d[i] = wr[32];
          vj_d[i]  = wr[31:0];
          wr = wake(qkb_q[i], qk_q[i], vk_q[i], CDB_sgn, CDB_ROB_name, CDB_result,
                    LSB_CDB_sgn, LSB_CDB_ROB_name, LSB_CDB_result);
          qkb_d[i] = wr[32];
          vk_d[i]  = wr[31:0];
        end
      end
      if (sel_found) begin
        alu_sgn_d       = 1'b1;
        alu_op_d        = op_q[sel_idx];
        alu_rob_d       = rob_q[sel_idx];
        alu_lhs_d       = vj_q[sel_idx];
        alu_rhs_d       = vk_q[sel_idx];
        busy_d[sel_idx] = 1'b0;
      end
      // The free slot is never the issuing one, since the issuing entry is still busy here.
      if (dp_sgn && free_found) begin
        busy_d[free_idx] = 1'b1;
        op_d[free_idx]   = dp_opcode;
        rob_d[free_idx]  = dp_ROB_name;
        qj_d[free_idx]   = dp_Qj;
        qk_d[free_idx]   = dp_Qk;
        wr = wake(dp_Qj_busy, dp_Qj, dp_Vj, CDB_sgn, CDB_ROB_name, CDB_result,
                  LSB_CDB_sgn, LSB_CDB_ROB_name, LSB_CDB_result);
        qjb_d[free_idx] = wr[32];
        vj_d[free_idx]  = wr[31:0];
        wr = wake(dp_Qk_busy, dp_Qk, dp_Vk, CDB_sgn, CDB_ROB_name, CDB_result,
                  LSB_CDB_sgn, LSB_CDB_ROB_name, LSB_CDB_result);
        qkb_d[free_idx] = wr[32];
        vk_d[free_idx]  = wr[31:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q    <= '0;
      qjb_q     <= '0;
      qkb_q     <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        op_q[i]  <= '0;
        rob_q[i] <= '0;
        qj_q[i]  <= '0;
        qk_q[i]  <= '0;
        vj_q[i]  <= '0;
        vk_q[i]  <= '0;
      end
      alu_sgn_q <= 1'b0;
      alu_op_q  <= '0;
      alu_rob_q <= '0;
      alu_lhs_q <= '0;
      alu_rhs_q <= '0;
    end else begin
      busy_q    <= busy_d;
      qjb_q     <= qjb_d;
      qkb_q     <= qkb_d;
      op_q      <= op_d;
      rob_q     <= rob_d;
      qj_q      <= qj_d;
      qk_q      <= qk_d;
      vj_q      <= vj_d;
      vk_q      <= vk_d;
      alu_sgn_q <= alu_sgn_d;
      alu_op_q  <= alu_op_d;
      alu_rob_q <= alu_rob_d;
      alu_lhs_q <= alu_lhs_d;
      alu_rhs_q <= alu_rhs_d;
    end
  end

  assign ALU_sgn      = alu_sgn_q;
  assign ALU_opcode   = alu_op_q;
  assign ALU_ROB_name = alu_rob_q;
  assign ALU_lhs      = alu_lhs_q;
  assign ALU_rhs      = alu_rhs_q;

endmodule
